// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush sequencer bundle: pipeline stages drive requests (master), controller answers (slave).
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif
`ifndef STALL_BUS
`define STALL_BUS 5:0
`endif
`ifndef PC_INIT
`define PC_INIT 32'hBFC0_0000
`endif
`ifndef STOP
`define STOP 1'b1
`endif

interface pipe_stall_ctrl_if;
  logic                 stallreq_if;
  logic                 stallreq_id;
  logic                 exe_div_req;
  logic                 stallreq_mem;
  logic                 mem_exc_valid;
  logic [`INST_ADDR_BUS] mem_exc_pc;
  logic [`STALL_BUS]    stall;
  logic                 flush;
  logic [`INST_ADDR_BUS] flush_pc;
  logic                 div_done;
  logic                 bus_timeout;

  modport master (
    output stallreq_if, stallreq_id, exe_div_req, stallreq_mem, mem_exc_valid, mem_exc_pc,
    input  stall, flush, flush_pc, div_done, bus_timeout
  );

  modport slave (
    input  stallreq_if, stallreq_id, exe_div_req, stallreq_mem, mem_exc_valid, mem_exc_pc,
    output stall, flush, flush_pc, div_done, bus_timeout
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Merges stage stall requests, times multi-cycle divides and sequences exception flushes.
// Optional bus-wait watchdog compiled in with macro STALL_CTRL_TIMEOUT_EN.
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif
`ifndef STALL_BUS
`define STALL_BUS 5:0
`endif
`ifndef PC_INIT
`define PC_INIT 32'hBFC0_0000
`endif

module pipe_stall_ctrl #(
  parameter int unsigned DIV_CYCLES     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  pipe_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DIV   = 2'd1,
    DONE  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int unsigned     CW       = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  localparam logic [`STALL_BUS] STALL_NONE = 6'b000000;
  localparam logic [`STALL_BUS] STALL_IF   = 6'b000011;
  localparam logic [`STALL_BUS] STALL_ID   = 6'b000111;
  localparam logic [`STALL_BUS] STALL_EXE  = 6'b001111;
  localparam logic [`STALL_BUS] STALL_MEM  = 6'b011111;

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic [`INST_ADDR_BUS] flush_pc_q;
  logic                 exc_accept;
  logic                 div_stall;

  // An exception is only taken once the data bus is free; FLUSH ignores everything.
  assign exc_accept = bus.mem_exc_valid && !bus.stallreq_mem && (state != FLUSH);
  assign div_stall  = ((state == RUN) && bus.exe_div_req) || (state == DIV);

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state      <= RUN;
      cnt        <= '0;
      flush_pc_q <= `PC_INIT;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (exc_accept) begin
        flush_pc_q <= bus.mem_exc_pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (exc_accept) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end else if (bus.exe_div_req) begin
          state_nxt = DIV;
          cnt_nxt   = CNT_LOAD;
        end
      end
      DIV: begin
        if (exc_accept) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_ONE) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      DONE: begin
        state_nxt = exc_accept ? FLUSH : RUN;
        cnt_nxt   = '0;
      end
      FLUSH: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Highest stage wins; a pending exception freezes everything younger than MEM.
  always_comb begin
    bus.stall    = STALL_NONE;
    bus.flush    = 1'b0;
    bus.div_done = 1'b0;
    if (!cpu_rst_n) begin
      bus.stall = STALL_NONE;
    end else if (state == FLUSH) begin
      bus.flush = 1'b1;
    end else begin
      bus.div_done = (state == DONE);
      if (bus.stallreq_mem || bus.mem_exc_valid) begin
        bus.stall = STALL_MEM;
      end else if (div_stall) begin
        bus.stall = STALL_EXE;
      end else if (bus.stallreq_id) begin
        bus.stall = STALL_ID;
      end else if (bus.stallreq_if) begin
        bus.stall = STALL_IF;
      end
    end
  end

  assign bus.flush_pc = flush_pc_q;

`ifdef STALL_CTRL_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;
  logic        bus_wait;

  assign bus_wait = bus.stallreq_if || bus.stallreq_mem;

  // Saturates at the limit so a long wait raises exactly one pulse.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      to_cnt <= '0;
    end else if ((state == FLUSH) || !bus_wait) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LIMIT) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  assign bus.bus_timeout = cpu_rst_n && bus_wait && (state != FLUSH) && (to_cnt == TO_LAST);
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign bus.bus_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: driver queues per-cycle expectations, monitor checks at negedge.
`ifndef PC_INIT
`define PC_INIT 32'hBFC0_0000
`endif

module tb_pipe_stall_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus();

  pipe_stall_ctrl #(
    .DIV_CYCLES     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .bus         (bus)
  );

`ifdef STALL_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        div_done;
    logic        bus_timeout;
  } obs_t;

  typedef struct {
    int   id;
    obs_t exp;
  } rec_t;

  localparam logic [5:0] S0   = 6'b000000;
  localparam logic [5:0] SIF  = 6'b000011;
  localparam logic [5:0] SID  = 6'b000111;
  localparam logic [5:0] SEX  = 6'b001111;
  localparam logic [5:0] SMEM = 6'b011111;

  // Request vector order: {stallreq_if, stallreq_id, exe_div_req, stallreq_mem, mem_exc_valid}
  localparam logic [4:0] R0   = 5'b00000;
  localparam logic [4:0] RIF  = 5'b10000;
  localparam logic [4:0] RID  = 5'b01000;
  localparam logic [4:0] RDV  = 5'b00100;
  localparam logic [4:0] RMEM = 5'b00010;
  localparam logic [4:0] REXC = 5'b00001;

  localparam logic [31:0] PI  = `PC_INIT;
  localparam logic [31:0] PE1 = 32'hBFC0_0380;
  localparam logic [31:0] PE2 = 32'h8000_0180;
  localparam logic [31:0] PE3 = 32'h0000_1000;

  rec_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   step_no = 0;
  rec_t mon_rec;
  obs_t mon_act;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_rec = exp_q.pop_front();
      mon_act = {bus.stall, bus.flush, bus.flush_pc, bus.div_done, bus.bus_timeout};
      checks++;
      if (mon_act !== mon_rec.exp) begin
        errors++;
        $display("FAIL step%0d: got stall=%b flush=%b flush_pc=%h div_done=%b bus_timeout=%b, want stall=%b flush=%b flush_pc=%h div_done=%b bus_timeout=%b",
                 mon_rec.id, mon_act.stall, mon_act.flush, mon_act.flush_pc, mon_act.div_done,
                 mon_act.bus_timeout, mon_rec.exp.stall, mon_rec.exp.flush, mon_rec.exp.flush_pc,
                 mon_rec.exp.div_done, mon_rec.exp.bus_timeout);
      end
    end
  end

  task automatic step(input logic rst, input logic [4:0] req, input logic [31:0] pc,
                      input logic [5:0] es, input logic ef, input logic [31:0] epc,
                      input logic ed, input logic et);
    rec_t r;
    step_no++;
    rst_n = rst;
    {bus.stallreq_if, bus.stallreq_id, bus.exe_div_req, bus.stallreq_mem, bus.mem_exc_valid} = req;
    bus.mem_exc_pc = pc;
    r.id  = step_no;
    r.exp = {es, ef, epc, ed, et};
    exp_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {bus.stallreq_if, bus.stallreq_id, bus.exe_div_req, bus.stallreq_mem, bus.mem_exc_valid} = R0;
    bus.mem_exc_pc = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held: stall forced off even with requests present
    step(1'b0, RMEM | RIF, '0, S0, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, R0, '0, S0, 1'b0, PI, 1'b0, 1'b0);

    // Stall priority
    step(1'b1, RID | RIF, '0, SID, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, RID | RIF, '0, SID, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, R0, '0, S0, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, RIF, '0, SIF, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, RMEM | RIF, '0, SMEM, 1'b0, PI, 1'b0, 1'b0);

    // Full divide, DIV_CYCLES=4
    step(1'b1, RDV, '0, SEX, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, RDV, '0, SEX, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, RDV | RID, '0, SEX, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, RDV, '0, SEX, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, RDV, '0, S0, 1'b0, PI, 1'b1, 1'b0);
    step(1'b1, R0, '0, S0, 1'b0, PI, 1'b0, 1'b0);

    // Exception aborts a divide; flush cycle ignores inputs
    step(1'b1, RDV, '0, SEX, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, RDV, '0, SEX, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, RDV | REXC, PE1, SMEM, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, RID | RMEM, '0, S0, 1'b1, PE1, 1'b0, 1'b0);
    step(1'b1, R0, '0, S0, 1'b0, PE1, 1'b0, 1'b0);
    step(1'b1, R0, '0, S0, 1'b0, PE1, 1'b0, 1'b0);

    // Exception held off by data-bus wait
    step(1'b1, REXC | RMEM, PE2, SMEM, 1'b0, PE1, 1'b0, 1'b0);
    step(1'b1, REXC | RMEM, PE2, SMEM, 1'b0, PE1, 1'b0, 1'b0);
    step(1'b1, REXC | RMEM, PE2, SMEM, 1'b0, PE1, 1'b0, 1'b0);
    step(1'b1, REXC, PE2, SMEM, 1'b0, PE1, 1'b0, 1'b0);
    step(1'b1, R0, '0, S0, 1'b1, PE2, 1'b0, 1'b0);
    step(1'b1, R0, '0, S0, 1'b0, PE2, 1'b0, 1'b0);

    // Exception and divide request together: exception wins, no divide
    step(1'b1, RDV | REXC, PE3, SMEM, 1'b0, PE2, 1'b0, 1'b0);
    step(1'b1, R0, '0, S0, 1'b1, PE3, 1'b0, 1'b0);
    step(1'b1, R0, '0, S0, 1'b0, PE3, 1'b0, 1'b0);

    // Async reset mid-divide, then a clean divide from scratch
    step(1'b1, RDV, '0, SEX, 1'b0, PE3, 1'b0, 1'b0);
    step(1'b1, RDV, '0, SEX, 1'b0, PE3, 1'b0, 1'b0);
    step(1'b0, RDV, '0, S0, 1'b0, PI, 1'b0, 1'b0);
    step(1'b1, R0, '0, S0, 1'b0, PI, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, RDV, '0, SEX, 1'b0, PI, 1'b0, 1'b0);
    end
    step(1'b1, RDV, '0, S0, 1'b0, PI, 1'b1, 1'b0);
    step(1'b1, R0, '0, S0, 1'b0, PI, 1'b0, 1'b0);

    // Long data-bus wait: single watchdog pulse on the 8th stalled cycle when compiled in
    for (int i = 0; i < 12; i++) begin
      step(1'b1, RMEM, '0, SMEM, 1'b0, PI, 1'b0, TO_EN && (i == 7));
    end
    step(1'b1, R0, '0, S0, 1'b0, PI, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
